// File: rtl/twilight_sequencer.sv
// Frame-synchronous night/dawn/day/dusk fade sequencer for the sky-gradient generator.
// All updates land on frame strobes so fade_level never changes mid-frame.
module twilight_sequencer #(
  parameter int STEP_SIZE   = 4,
  parameter int STEP_DIV    = 2,
  parameter int HOLD_FRAMES = 120
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic       frame,
  input  logic       en,
  input  logic       pause,
  input  logic       force_req,
  input  logic       force_day,
  output logic [7:0] fade_level,
  output logic [1:0] phase,
  output logic       phase_done
);

  localparam int HCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int DCW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_FRAMES - 1);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(STEP_DIV - 1);
  localparam logic [8:0]     STEP9     = 9'(STEP_SIZE);

  typedef enum logic [1:0] {
    NIGHT_HOLD = 2'd0,
    DAWN       = 2'd1,
    DAY_HOLD   = 2'd2,
    DUSK       = 2'd3
  } state_t;

  state_t           r_state, w_state_n;
  logic [7:0]       r_fade, w_fade_n;
  logic [HCW-1:0]   r_hold, w_hold_n;
  logic [DCW-1:0]   r_div, w_div_n;
  logic             r_done, w_done_n;
  logic             r_pend, w_pend_n;
  logic             r_target, w_target_n;

  logic             w_qual;
  logic             w_force;
  logic             w_force_day;
  logic [8:0]       w_sum;
  logic signed [8:0] w_diff;
  logic [7:0]       w_up;
  logic [7:0]       w_dn;

  assign w_qual      = frame & en & ~pause;
  // A request arriving on the frame edge itself is honoured immediately.
  assign w_force     = frame & (r_pend | force_req);
  assign w_force_day = force_req ? force_day : r_target;

  assign w_sum  = {1'b0, r_fade} + STEP9;
  assign w_diff = $signed({1'b0, r_fade}) - $signed(STEP9);
  assign w_up   = w_sum[8] ? 8'hFF : w_sum[7:0];
  assign w_dn   = w_diff[8] ? 8'h00 : w_diff[7:0];

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      r_state  <= NIGHT_HOLD;
      r_fade   <= 8'h00;
      r_hold   <= '0;
      r_div    <= '0;
      r_done   <= 1'b0;
      r_pend   <= 1'b0;
      r_target <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_fade   <= w_fade_n;
      r_hold   <= w_hold_n;
      r_div    <= w_div_n;
      r_done   <= w_done_n;
      r_pend   <= w_pend_n;
      r_target <= w_target_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_fade_n   = r_fade;
    w_hold_n   = r_hold;
    w_div_n    = r_div;
    w_done_n   = 1'b0;
    w_pend_n   = r_pend;
    w_target_n = r_target;

    if (force_req) begin
      w_pend_n   = 1'b1;
      w_target_n = force_day;
    end

    if (w_force) begin
      w_state_n = w_force_day ? DAY_HOLD : NIGHT_HOLD;
      w_fade_n  = w_force_day ? 8'hFF : 8'h00;
      w_hold_n  = '0;
      w_div_n   = '0;
      w_pend_n  = 1'b0;
    end else if (w_qual) begin
      case (r_state)
        NIGHT_HOLD, DAY_HOLD: begin
          if (r_hold == HOLD_LAST) begin
            w_hold_n  = '0;
            w_div_n   = '0;
            w_state_n = (r_state == NIGHT_HOLD) ? DAWN : DUSK;
          end else begin
            w_hold_n = r_hold + HCW'(1);
          end
        end
        DAWN: begin
          if (r_div == DIV_LAST) begin
            w_fade_n = w_up;
            w_div_n  = '0;
            if (w_up == 8'hFF) begin
              w_state_n = DAY_HOLD;
              w_hold_n  = '0;
              w_done_n  = 1'b1;
            end
          end else begin
            w_div_n = r_div + DCW'(1);
          end
        end
        DUSK: begin
          if (r_div == DIV_LAST) begin
            w_fade_n = w_dn;
            w_div_n  = '0;
            if (w_dn == 8'h00) begin
              w_state_n = NIGHT_HOLD;
              w_hold_n  = '0;
              w_done_n  = 1'b1;
            end
          end else begin
            w_div_n = r_div + DCW'(1);
          end
        end
      endcase
    end
  end

  assign fade_level = r_fade;
  assign phase      = r_state;
  assign phase_done = r_done;

endmodule

// File: tb/tb_twilight_sequencer.sv
// Self-checking bench for twilight_sequencer: three parameterisations share one
// stimulus stream; the active one is picked by sel and compared against a scoreboard.
module tb_twilight_sequencer;

   // Record of one stimulus cycle and the outputs expected right after its edge
   typedef struct {
      logic       frame;
      logic       en;
      logic       pause;
      logic       freq;
      logic       fday;
      logic [7:0] fade;
      logic [1:0] phase;
      logic       done;
   } vec_t;

   logic       clock;
   logic       rst;
   logic       frame;
   logic       en;
   logic       pause;
   logic       forceReq;
   logic       forceDay;
   logic [7:0] fadeA, fadeB, fadeC;
   logic [1:0] phaseA, phaseB, phaseC;
   logic       doneA, doneB, doneC;
   logic [7:0] actFade;
   logic [1:0] actPhase;
   logic       actDone;
   int         sel;
   int         vecCount;
   int         missCount;
   vec_t       sbq[$];
   vec_t       basicTab[16];

   // Fast configuration used for the cycle, pause, force and reset tests
   twilight_sequencer #(.STEP_SIZE(64), .STEP_DIV(1), .HOLD_FRAMES(2)) uFast (
      .clk_pix(clock), .rst(rst), .frame(frame), .en(en), .pause(pause),
      .force_req(forceReq), .force_day(forceDay),
      .fade_level(fadeA), .phase(phaseA), .phase_done(doneA));

   // Default parameters for the long-hold / divided-ramp test
   twilight_sequencer uDef (
      .clk_pix(clock), .rst(rst), .frame(frame), .en(en), .pause(pause),
      .force_req(forceReq), .force_day(forceDay),
      .fade_level(fadeB), .phase(phaseB), .phase_done(doneB));

   // Large step to exercise saturation at both ends
   twilight_sequencer #(.STEP_SIZE(100), .STEP_DIV(1), .HOLD_FRAMES(2)) uSat (
      .clk_pix(clock), .rst(rst), .frame(frame), .en(en), .pause(pause),
      .force_req(forceReq), .force_day(forceDay),
      .fade_level(fadeC), .phase(phaseC), .phase_done(doneC));

   // Route the instance under test to the comparison signals
   assign actFade  = (sel == 1) ? fadeB  : (sel == 2) ? fadeC  : fadeA;
   assign actPhase = (sel == 1) ? phaseB : (sel == 2) ? phaseC : phaseA;
   assign actDone  = (sel == 1) ? doneB  : (sel == 2) ? doneC  : doneA;

   // Free-running pixel clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic f, input logic e, input logic p, input logic fr,
                               input logic fd, input logic [7:0] fl, input logic [1:0] ph,
                               input logic d);
      vec_t v;
      v.frame = f; v.en = e; v.pause = p; v.freq = fr; v.fday = fd;
      v.fade = fl; v.phase = ph; v.done = d;
      return v;
   endfunction

   // Pop the oldest expectation and compare it to the selected DUT
   task automatic checkOutput(input string tag);
      vec_t e;
      vecCount++;
      if (sbq.size() == 0) begin
         missCount++;
         $display("[TB] FAIL %s: scoreboard empty, no expected value available", tag);
      end else begin
         e = sbq.pop_front();
         if (actFade !== e.fade || actPhase !== e.phase || actDone !== e.done) begin
            missCount++;
            $display("[TB] FAIL %s: got fade=%0d phase=%0d done=%0b, expected fade=%0d phase=%0d done=%0b",
                     tag, actFade, actPhase, actDone, e.fade, e.phase, e.done);
         end
      end
   endtask

   // Drive one vector for one edge, check, then spend one idle cycle
   task automatic applyStimulus(input vec_t v, input string tag);
      frame    = v.frame;
      en       = v.en;
      pause    = v.pause;
      forceReq = v.freq;
      forceDay = v.fday;
      sbq.push_back(v);
      @(posedge clock); #1;
      checkOutput(tag);
      frame    = 1'b0;
      forceReq = 1'b0;
      en       = 1'b1;
      pause    = 1'b0;
      @(posedge clock); #1;
   endtask

   // Qualifying frames without comparison, to advance long sequences
   task automatic runFrames(input int n);
      for (int i = 0; i < n; i++) begin
         frame = 1'b1; en = 1'b1; pause = 1'b0;
         @(posedge clock); #1;
         frame = 1'b0;
         @(posedge clock); #1;
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      frame = 1'b0; en = 1'b1; pause = 1'b0; forceReq = 1'b0; forceDay = 1'b0;
      @(posedge clock); #1;
      rst = 1'b0;
   endtask

   // Main test sequence
   initial begin
      vecCount  = 0;
      missCount = 0;
      sel       = 0;

      // Full cycle with 64/1/2: frames walk night -> dawn -> day -> dusk -> night
      basicTab[0]  = mk(1,1,0,0,0,   0,0,0);
      basicTab[1]  = mk(1,1,0,0,0,   0,1,0);
      basicTab[2]  = mk(1,1,0,0,0,  64,1,0);
      basicTab[3]  = mk(1,1,0,0,0, 128,1,0);
      basicTab[4]  = mk(1,1,0,0,0, 192,1,0);
      basicTab[5]  = mk(1,1,0,0,0, 255,2,1);
      basicTab[6]  = mk(0,1,0,0,0, 255,2,0);
      basicTab[7]  = mk(1,1,0,0,0, 255,2,0);
      basicTab[8]  = mk(1,1,0,0,0, 255,3,0);
      basicTab[9]  = mk(1,1,0,0,0, 191,3,0);
      basicTab[10] = mk(1,1,0,0,0, 127,3,0);
      basicTab[11] = mk(1,1,0,0,0,  63,3,0);
      basicTab[12] = mk(1,1,0,0,0,   0,0,1);
      basicTab[13] = mk(0,1,0,0,0,   0,0,0);
      basicTab[14] = mk(1,1,0,0,0,   0,0,0);
      basicTab[15] = mk(1,1,0,0,0,   0,1,0);

      doReset();
      applyStimulus(mk(0,1,0,0,0, 0,0,0), "reset_state");
      for (int i = 0; i < 16; i++)
         applyStimulus(basicTab[i], $sformatf("cycle_%0d", i));

      // Pause and en=0 freeze hold and ramp progress
      doReset();
      applyStimulus(mk(1,1,0,0,0, 0,0,0), "pause_hold_f1");
      for (int i = 0; i < 3; i++)
         applyStimulus(mk(1,1,1,0,0, 0,0,0), "pause_in_hold");
      applyStimulus(mk(1,0,0,0,0, 0,0,0), "en_low_in_hold");
      applyStimulus(mk(1,1,0,0,0, 0,1,0), "hold_resumed");
      applyStimulus(mk(1,1,0,0,0, 64,1,0), "dawn_64");
      applyStimulus(mk(1,1,0,0,0, 128,1,0), "dawn_128");
      for (int i = 0; i < 10; i++)
         applyStimulus(mk(1,1,1,0,0, 128,1,0), "pause_mid_dawn");
      applyStimulus(mk(1,1,0,0,0, 192,1,0), "dawn_resume_192");

      // Force: overwrite target between frames, apply on a paused frame
      doReset();
      applyStimulus(mk(1,1,0,0,0, 0,0,0), "force_pre_f1");
      applyStimulus(mk(0,1,1,1,0, 0,0,0), "force_req_night");
      applyStimulus(mk(0,1,1,1,1, 0,0,0), "force_req_day_overwrite");
      applyStimulus(mk(1,0,1,0,0, 255,2,0), "force_day_applied");
      applyStimulus(mk(1,1,0,0,0, 255,2,0), "day_hold_count");
      applyStimulus(mk(1,1,0,1,0, 0,0,0), "force_night_same_cycle");
      applyStimulus(mk(1,1,0,0,0, 0,0,0), "hold_cleared_after_force");
      applyStimulus(mk(1,1,0,0,0, 0,1,0), "dawn_after_force");

      // Async reset mid-dusk, then restart with two hold frames
      doReset();
      runFrames(9);
      applyStimulus(mk(1,1,0,0,0, 127,3,0), "dusk_127");
      #2 rst = 1'b1;
      #1;
      sbq.push_back(mk(0,1,0,0,0, 0,0,0));
      checkOutput("async_reset");
      #2 rst = 1'b0;
      @(posedge clock); #1;
      applyStimulus(mk(1,1,0,0,0, 0,0,0), "restart_hold1");
      applyStimulus(mk(1,1,0,0,0, 0,1,0), "restart_dawn");
      applyStimulus(mk(1,1,0,0,0, 64,1,0), "restart_64");

      // Saturation with STEP_SIZE=100
      sel = 2;
      doReset();
      applyStimulus(mk(1,1,0,0,0, 0,0,0), "sat_hold1");
      applyStimulus(mk(1,1,0,0,0, 0,1,0), "sat_dawn");
      applyStimulus(mk(1,1,0,0,0, 100,1,0), "sat_100");
      applyStimulus(mk(1,1,0,0,0, 200,1,0), "sat_200");
      applyStimulus(mk(1,1,0,0,0, 255,2,1), "sat_255");
      applyStimulus(mk(1,1,0,0,0, 255,2,0), "sat_day_hold");
      applyStimulus(mk(1,1,0,0,0, 255,3,0), "sat_dusk");
      applyStimulus(mk(1,1,0,0,0, 155,3,0), "sat_155");
      applyStimulus(mk(1,1,0,0,0, 55,3,0), "sat_55");
      applyStimulus(mk(1,1,0,0,0, 0,0,1), "sat_0");

      // Default parameters: 120 hold frames, ramp of 4 every 2 frames
      sel = 1;
      doReset();
      runFrames(118);
      applyStimulus(mk(1,1,0,0,0, 0,0,0), "def_frame119");
      applyStimulus(mk(1,1,0,0,0, 0,1,0), "def_frame120_dawn");
      runFrames(125);
      applyStimulus(mk(1,1,0,0,0, 252,1,0), "def_dawn126_252");
      applyStimulus(mk(1,1,0,0,0, 252,1,0), "def_dawn127_div");
      applyStimulus(mk(1,1,0,0,0, 255,2,1), "def_dawn128_sat");
      applyStimulus(mk(0,1,0,0,0, 255,2,0), "def_done_cleared");

      if (sbq.size() != 0) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule

// File: doc/twilight_sequencer.md
Name: twilight_sequencer

Overview:
Generates the fade_level that drives the sky-gradient background generator, sequencing a repeating night -> dawn -> day -> dusk cycle. fade_level changes only at frame boundaries, so the sky never tears mid-frame. The block sits in the pixel-clock domain beside the background generator and takes the frame-start strobe from the display timing block. It also provides pause and force-to-day/night controls for the game/demo logic.

Parameters:
STEP_SIZE, 4, fade_level increment/decrement per ramp step (1..255)
STEP_DIV, 2, qualifying frames per ramp step (>=1)
HOLD_FRAMES, 120, qualifying frames spent in each hold state (>=1)

Ports:
clk_pix  input  1  pixel clock
rst  input  1  asynchronous reset, active-high
frame  input  1  one-cycle strobe at start of vertical blanking
en  input  1  sequencer enable; 0 freezes the cycle
pause  input  1  1 freezes the cycle (same effect as en=0)
force_req  input  1  one-cycle request to jump to a fixed phase
force_day  input  1  target of force_req, sampled with it: 1=day, 0=night
fade_level  output  8  blend factor to the background generator (0=night, 255=day)
phase  output  2  current state: 0 NIGHT_HOLD, 1 DAWN, 2 DAY_HOLD, 3 DUSK
phase_done  output  1  one-cycle pulse when a ramp completes

Behaviour:
- Single clock (clk_pix). Asynchronous active-high reset (rst) applies immediately, including mid-ramp.
- Reset values: fade_level=0, phase=0 (NIGHT_HOLD), phase_done=0, hold_cnt=0, div_cnt=0, force pending=0.
- Qualifying frame: frame=1 AND en=1 AND pause=0. All state, counter and fade_level updates happen only on the clk_pix edge that samples a qualifying frame (force handling is the one exception, below). Outputs are registered and stable for the entire frame.
- NIGHT_HOLD / DAY_HOLD:
  - hold_cnt increments on each qualifying frame.
  - On the frame where hold_cnt==HOLD_FRAMES-1: clear hold_cnt, go to DAWN (from night) or DUSK (from day).
  - fade_level is unchanged in hold states.
- DAWN / DUSK:
  - div_cnt counts qualifying frames. On a frame where div_cnt==STEP_DIV-1, apply one step and clear div_cnt; otherwise div_cnt+1.
  - DAWN step: fade_level = min(fade_level+STEP_SIZE, 255), using 9-bit sum and saturation.
  - DUSK step: fade_level = max(fade_level-STEP_SIZE, 0), using signed 9-bit difference and clamp.
  - DAWN to DAY_HOLD: on the same edge where the stepped value equals 255.
  - DUSK to NIGHT_HOLD: on the same edge where the stepped value equals 0.
  - On either transition, phase_done=1 for exactly the following cycle, then 0.
  - div_cnt and hold_cnt are cleared on every state change.
- Force:
  - force_req=1 latches pending=1 and target=force_day. A later force_req before the force is applied overwrites the target.
  - On the next frame=1 edge, the force applies regardless of en and pause:
    - target=1: fade_level=255, phase=DAY_HOLD.
    - target=0: fade_level=0, phase=NIGHT_HOLD.
  - Applying the force clears counters and pending and does not pulse phase_done.
  - force_req and frame in the same cycle: the request is applied on that same edge.
  - Force pending on a qualifying frame: the force wins over the normal step or transition.
- Pausing mid-ramp preserves fade_level, div_cnt and hold_cnt exactly. Resuming continues from the same point.
- Non-qualifying frame strobes, and all other cycles, leave every register unchanged, except that phase_done self-clears.

Test Plan:
- Reset, then STEP_SIZE=64, STEP_DIV=1, HOLD_FRAMES=2, run 14 qualifying frames:
  - phase sequence: 0,0,1,1,1,1,2,2,3,3,3,3,0,0
  - fade_level after each frame: 0,0,64,128,192,255,255,255,191,127,63,0,0,0
  - phase_done pulses once after the 255 step and once after the 0 step.
- Defaults (4/2/120): from reset, 120 frames to enter DAWN; fade_level reaches 255 after a further 128 frames (252 then saturate); phase_done pulses once.
- Pause/en: hold pause=1 across 10 frame strobes mid-DAWN (fade_level=128) -> fade_level, phase and counters are unchanged; after release, the next qualifying frame gives 192 (64/1/2 config).
- Force: in NIGHT_HOLD, pulse force_req with force_day=1 between frames, with pause=1 -> at the next frame, fade_level=255 and phase=2, with no phase_done. Then force_req with force_day=0 in the same cycle as frame -> fade_level=0 and phase=0 on that edge.
- Async reset: assert rst mid-DUSK (fade_level=127) between clock edges -> all outputs go to reset values immediately. After release, the cycle restarts from NIGHT_HOLD with 2 hold frames.
- Saturation: STEP_SIZE=100, STEP_DIV=1 -> DAWN gives 100, 200, 255; DUSK gives 155, 55, 0. No wrap-around.
